tx_sweep_multi: RTL and testbench

Multi-channel frequency-sweep transmitter driven by the system 50 MHz clock. A `syncpulse` edge starts a stepped linear sweep from `F1` to `F2`, given in 100 Hz units. Each of `CH` channels outputs a square wave from a shared phase accumulator, with a fixed per-channel phase offset. It is the parametrised successor of the single-channel TX and adds:
- channel count, widths and step rate set by parameters;
- up/down sweep;
- single, repeat and feedback-track modes, where the track mode uses `i_fid` against `i_set`.

---
 rtl/tx_sweep_multi.sv | 142 ++++++++++++++
 tb/tb_tx_sweep_multi.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tx_sweep_multi.sv
// Multi-channel stepped linear-sweep square-wave transmitter.
// One shared phase accumulator drives CH lanes, each offset by k*360/CH degrees.

module tx_sweep_lane #(
    parameter int            PW  = 32,
    parameter logic [PW-1:0] OFS = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [PW-1:0] phase,
    output logic          tx
);
    logic [PW-1:0] ph_k;

    assign ph_k = phase + OFS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx <= 1'b0;
        else        tx <= en & ph_k[PW-1];
    end
endmodule

module tx_sweep_multi #(
    parameter int CH       = 4,
    parameter int FW       = 16,
    parameter int PW       = 32,
    parameter int DW       = 16,
    parameter int STEP_DIV = 5000,
    parameter int INC_K    = 8590
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          syncpulse,
    input  logic [FW-1:0] F1,
    input  logic [FW-1:0] F2,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] i_fid,
    input  logic [DW-1:0] i_set,
    input  logic [CH-1:0] ch_en,
    output logic [CH-1:0] tx_out,
    output logic [FW-1:0] cur_f,
    output logic          busy,
    output logic          done,
    output logic          locked
);
    localparam int              CW       = $clog2(CH);
    localparam int              CNTW     = $clog2(STEP_DIV);
    localparam logic [CNTW-1:0] DIV_LAST = CNTW'(STEP_DIV - 1);
    localparam logic [14:0]     INC      = 15'(INC_K);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    logic [0:0]      state;
    logic            sync_d;
    logic            trig;
    logic [FW-1:0]   f1_l;
    logic [FW-1:0]   f2_l;
    logic [1:0]      mode_l;
    logic            dir;
    logic [CNTW-1:0] div_cnt;
    logic [PW-1:0]   phase;
    logic [FW+14:0]  prod;
    logic [PW-1:0]   inc;
    logic            sweeping;
    logic            hold;
    logic            at_end;

    assign trig     = syncpulse & ~sync_d;
    assign sweeping = (state == S_SWEEP);
    assign busy     = sweeping;
    assign prod     = cur_f * INC;
    assign inc      = PW'(prod);
    assign at_end   = (cur_f == f2_l);
    // Track mode freezes the step divider while the feedback is at/above threshold.
    assign hold     = sweeping && (mode_l == 2'd2) && (i_fid >= i_set);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sync_d  <= 1'b0;
            f1_l    <= '0;
            f2_l    <= '0;
            mode_l  <= 2'd0;
            dir     <= 1'b1;
            cur_f   <= '0;
            div_cnt <= '0;
            phase   <= '0;
            done    <= 1'b0;
            locked  <= 1'b0;
        end else begin
            sync_d <= syncpulse;
            done   <= 1'b0;
            if (trig) begin
                f1_l    <= F1;
                f2_l    <= F2;
                mode_l  <= (mode == 2'd3) ? 2'd0 : mode;
                dir     <= (F2 >= F1);
                cur_f   <= F1;
                div_cnt <= '0;
                phase   <= '0;
                state   <= S_SWEEP;
                locked  <= 1'b0;
            end else if (sweeping) begin
                phase  <= phase + inc;
                locked <= hold;
                if (!hold) begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!at_end) begin
                            cur_f <= dir ? cur_f + 1'b1 : cur_f - 1'b1;
                        end else if (mode_l == 2'd1) begin
                            cur_f <= f1_l;
                            done  <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            phase <= '0;
                            done  <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
            end else begin
                locked <= 1'b0;
            end
        end
    end

    // Lane k samples the shared phase shifted by k/CH of a full turn.
    for (genvar k = 0; k < CH; k++) begin : g_lane
        localparam logic [PW-1:0] OFS = PW'(k) << (PW - CW);
        tx_sweep_lane #(.PW(PW), .OFS(OFS)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (ch_en[k] & sweeping),
            .phase (phase),
            .tx    (tx_out[k])
        );
    end
endmodule

// File: tb/tb_tx_sweep_multi.sv
// Directed vector bench: short-divider instance for sweep/mode behaviour,
// full-rate single-channel instance for the output-frequency check.
module tb_tx_sweep_multi;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    logic        a_sync = 0;
    logic [15:0] a_f1 = 0, a_f2 = 0, a_fid = 0, a_set = 16'd50;
    logic [1:0]  a_mode = 0;
    logic [3:0]  a_en = 4'hF;
    logic [3:0]  a_tx;
    logic [15:0] a_cf;
    logic        a_busy, a_done, a_locked;

    logic        b_sync = 0;
    logic [15:0] b_f1 = 0, b_f2 = 0, b_fid = 0, b_set = 16'd50;
    logic [1:0]  b_mode = 0;
    logic [0:0]  b_en = 1'b1;
    logic [0:0]  b_tx;
    logic [15:0] b_cf;
    logic        b_busy, b_done, b_locked;

    tx_sweep_multi #(.CH(4), .FW(16), .PW(32), .DW(16), .STEP_DIV(4), .INC_K(8590)) dut_a (
        .clk(clk), .rst_n(rst_n), .syncpulse(a_sync), .F1(a_f1), .F2(a_f2), .mode(a_mode),
        .i_fid(a_fid), .i_set(a_set), .ch_en(a_en), .tx_out(a_tx), .cur_f(a_cf),
        .busy(a_busy), .done(a_done), .locked(a_locked));

    tx_sweep_multi #(.CH(1), .FW(16), .PW(32), .DW(16), .STEP_DIV(5000), .INC_K(8590)) dut_b (
        .clk(clk), .rst_n(rst_n), .syncpulse(b_sync), .F1(b_f1), .F2(b_f2), .mode(b_mode),
        .i_fid(b_fid), .i_set(b_set), .ch_en(b_en), .tx_out(b_tx), .cur_f(b_cf),
        .busy(b_busy), .done(b_done), .locked(b_locked));

    typedef struct {
        logic sync; logic [15:0] f1; logic [15:0] f2; logic [1:0] mode; logic [15:0] fid;
        logic [3:0] en; logic [15:0] cf; logic busy; logic done; logic lk; logic chk; logic [3:0] tx;
    } vec_t;
    vec_t tbl[$];

    int n_vec = 0, n_bad = 0;
    int t0, t1, tog, x2, done_c, rises, dones, nr, d;
    logic prev, busy_at, busy_drop;
    int rt[11];

    function automatic void add(input logic sync, input int f1, input int f2, input int mode,
                                input int fid, input logic [3:0] en, input int cf,
                                input logic busy, input logic done, input logic lk,
                                input logic chk, input logic [3:0] tx);
        vec_t v;
        v.sync = sync; v.f1 = 16'(f1); v.f2 = 16'(f2); v.mode = 2'(mode); v.fid = 16'(fid);
        v.en = en; v.cf = 16'(cf); v.busy = busy; v.done = done; v.lk = lk; v.chk = chk; v.tx = tx;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_a"}, {a_tx, a_cf, a_busy, a_done, a_locked}, 0);
        chk({nm, "_b"}, {b_tx, b_cf, b_busy, b_done, b_locked}, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_zero("idle_after_reset");

        // up sweep 60..62, single mode
        add(1, 60, 62, 0, 0, 4'hF, 60, 1, 0, 0, 1, 4'h0);
        for (int i = 0; i < 3; i++) add(0, 60, 62, 0, 0, 4'hF, 60, 1, 0, 0, 1, 4'hC);
        for (int i = 0; i < 4; i++) add(0, 60, 62, 0, 0, 4'hF, 61, 1, 0, 0, 1, 4'hC);
        for (int i = 0; i < 4; i++) add(0, 60, 62, 0, 0, 4'hF, 62, 1, 0, 0, 1, 4'hC);
        add(0, 60, 62, 0, 0, 4'hF, 62, 0, 1, 0, 0, 4'h0);
        add(0, 60, 62, 0, 0, 4'hF, 62, 0, 0, 0, 1, 4'h0);
        // down sweep, lane 2 disabled, inputs scrambled mid-sweep
        add(1, 62, 60, 0, 0, 4'hB, 62, 1, 0, 0, 1, 4'h0);
        for (int i = 0; i < 3; i++) add(0, 99, 10, 1, 0, 4'hB, 62, 1, 0, 0, 1, 4'h8);
        for (int i = 0; i < 4; i++) add(0, 99, 10, 1, 0, 4'hB, 61, 1, 0, 0, 1, 4'h8);
        for (int i = 0; i < 4; i++) add(0, 99, 10, 1, 0, 4'hB, 60, 1, 0, 0, 1, 4'h8);
        add(0, 99, 10, 1, 0, 4'hB, 60, 0, 1, 0, 0, 4'h0);
        add(0, 99, 10, 1, 0, 4'hB, 60, 0, 0, 0, 1, 4'h0);
        // repeat mode: two full passes, then retrigger into a 70..70 single dwell
        add(1, 60, 62, 1, 0, 4'hF, 60, 1, 0, 0, 1, 4'h0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) add(0, 60, 62, 1, 0, 4'hF, 60, 1, 0, 0, 1, 4'hC);
            for (int i = 0; i < 4; i++) add(0, 60, 62, 1, 0, 4'hF, 61, 1, 0, 0, 1, 4'hC);
            for (int i = 0; i < 4; i++) add(0, 60, 62, 1, 0, 4'hF, 62, 1, 0, 0, 1, 4'hC);
            add(0, 60, 62, 1, 0, 4'hF, 60, 1, 1, 0, 1, 4'hC);
        end
        for (int i = 0; i < 2; i++) add(0, 60, 62, 1, 0, 4'hF, 60, 1, 0, 0, 1, 4'hC);
        add(1, 70, 70, 0, 0, 4'hF, 70, 1, 0, 0, 1, 4'hC);
        for (int i = 0; i < 3; i++) add(0, 70, 70, 0, 0, 4'hF, 70, 1, 0, 0, 1, 4'hC);
        add(0, 70, 70, 0, 0, 4'hF, 70, 0, 1, 0, 0, 4'h0);
        add(0, 70, 70, 0, 0, 4'hF, 70, 0, 0, 0, 1, 4'h0);
        // track mode: fid ramps 0,10,..,90 against threshold 50, then drops to 0
        add(1, 60, 62, 2, 0, 4'hF, 60, 1, 0, 0, 1, 4'h0);
        for (int i = 1; i <= 3; i++) add(0, 60, 62, 2, 10 * i, 4'hF, 60, 1, 0, 0, 1, 4'hC);
        add(0, 60, 62, 2, 40, 4'hF, 61, 1, 0, 0, 1, 4'hC);
        for (int i = 5; i <= 9; i++) add(0, 60, 62, 2, 10 * i, 4'hF, 61, 1, 0, 1, 1, 4'hC);
        for (int i = 0; i < 3; i++) add(0, 60, 62, 2, 0, 4'hF, 61, 1, 0, 0, 1, 4'hC);
        for (int i = 0; i < 4; i++) add(0, 60, 62, 2, 0, 4'hF, 62, 1, 0, 0, 1, 4'hC);
        add(0, 60, 62, 2, 0, 4'hF, 62, 0, 1, 0, 0, 4'h0);
        add(0, 60, 62, 2, 0, 4'hF, 62, 0, 0, 0, 1, 4'h0);

        foreach (tbl[i]) begin
            a_sync = tbl[i].sync; a_f1 = tbl[i].f1; a_f2 = tbl[i].f2; a_mode = tbl[i].mode;
            a_fid = tbl[i].fid; a_en = tbl[i].en;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i),
                {a_cf, a_busy, a_done, a_locked, (tbl[i].chk ? a_tx : 4'h0)},
                {tbl[i].cf, tbl[i].busy, tbl[i].done, tbl[i].lk, (tbl[i].chk ? tbl[i].tx : 4'h0)});
        end

        // Lane offsets at ~16-cycle period while track mode holds the step.
        a_sync = 1; a_f1 = 31250; a_f2 = 31252; a_mode = 2; a_fid = 100; a_en = 4'hB;
        @(posedge clk); #1 a_sync = 0;
        t0 = -1; t1 = -1; tog = 0; x2 = 0; prev = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk); #1;
            if (a_tx[1] && t1 < 0) t1 = c;
            if (a_tx[0] && t0 < 0) t0 = c;
            if (c > 1 && a_tx[0] !== prev) tog++;
            prev = a_tx[0];
            if (a_tx[2]) x2++;
        end
        chk("lane1_first_high", t1, 5);
        chk("lane0_first_high", t0, 9);
        chk("lane0_toggles_locked", tog, 7);
        chk("lane2_disabled_highs", x2, 0);
        chk("locked_hold", {a_cf, a_busy, a_locked}, {16'd31250, 1'b1, 1'b1});
        rst_n = 1'b0;
        #1 chk_zero("reset_mid_sweep");
        @(negedge clk) rst_n = 1'b1;
        a_fid = 0; a_mode = 0;
        repeat (5) @(posedge clk);
        #1 chk_zero("idle_after_mid_reset");

        // 50 kHz single dwell on the full-rate instance
        b_f1 = 500; b_f2 = 500; b_mode = 0; b_sync = 1;
        @(posedge clk); #1 b_sync = 0;
        done_c = -1; rises = 0; prev = 1'b0; busy_at = 1'b1;
        for (int c = 1; c <= 6000 && done_c < 0; c++) begin
            @(posedge clk); #1;
            if (b_tx[0] && !prev) rises++;
            prev = b_tx[0];
            if (b_done) begin done_c = c; busy_at = b_busy; end
        end
        chk("single_done_cycle", done_c, 5000);
        chk("single_busy_at_done", busy_at, 0);
        chk("single_rises", rises, 5);
        @(posedge clk); #1 chk("single_done_width", b_done, 0);

        // repeat mode: 10 periods of 50 kHz span 200 us
        b_mode = 1; b_sync = 1;
        @(posedge clk); #1 b_sync = 0;
        nr = 0; dones = 0; prev = 1'b0; busy_drop = 1'b0;
        for (int c = 1; c <= 12000 && nr < 11; c++) begin
            @(posedge clk); #1;
            if (b_tx[0] && !prev) begin rt[nr] = c; nr++; end
            prev = b_tx[0];
            if (b_done) dones++;
            if (!b_busy) busy_drop = 1'b1;
        end
        chk("repeat_rise_count", nr, 11);
        chk("repeat_first_rise", rt[0], 501);
        d = (nr == 11) ? rt[10] - rt[0] : -1;
        n_vec++;
        if (d < 9999 || d > 10001) begin
            n_bad++;
            $display("FAIL ten_periods: got %0d cycles expected 10000 +-1", d);
        end
        chk("repeat_done_pulses", dones, 2);
        chk("repeat_busy_drop", busy_drop, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
